// File: rtl/time_set_ctrl_pkg.sv
// Shared types and constants for the time-set controller: FSM states,
// field limits, edit-select encodings and the wrapping step helper.
package time_set_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_e;

    localparam logic [6:0] HOUR_MAX = 7'd23;
    localparam logic [6:0] MIN_MAX  = 7'd59;

    localparam logic [1:0] SEL_RUN  = 2'b00;
    localparam logic [1:0] SEL_HOUR = 2'b01;
    localparam logic [1:0] SEL_MIN  = 2'b10;

    // One step up or down inside 0..max, wrapping at both ends.
    function automatic logic [6:0] step_wrap(input logic [6:0] v,
                                             input logic [6:0] max,
                                             input logic       up);
        if (up)
            return (v >= max) ? 7'd0 : v + 7'd1;
        else
            return ((v == 7'd0) || (v > max)) ? max : v - 7'd1;
    endfunction

    function automatic logic [1:0] edit_sel_of(input state_e s);
        case (s)
            ST_SET_HOUR: return SEL_HOUR;
            ST_SET_MIN:  return SEL_MIN;
            default:     return SEL_RUN;
        endcase
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stable-level debounce and a
// one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    // The count only runs while the sample disagrees with the accepted level;
    // a sample matching the level again is a bounce and restarts it.
    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign o_press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time-set controller: mode button walks RUN -> hour -> minute -> RUN,
// up/down edit the selected field, and leaving minute edit strobes o_load.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_mode,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic [6:0] i_hour,
    input  logic [6:0] i_min,
    output logic       o_load,
    output logic [6:0] o_set_hour,
    output logic [6:0] o_set_min,
    output logic       o_setting,
    output logic [1:0] o_edit_sel
);

    logic mode_p, up_p, dn_p;
    logic up_ev, dn_ev;

    state_e     state_q, state_d;
    logic [6:0] hour_q, hour_d;
    logic [6:0] min_q, min_d;
    logic       load_q, load_d;
    logic       setting_q, setting_d;
    logic [1:0] sel_q, sel_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_mode), .o_press(mode_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_up), .o_press(up_p));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_down), .o_press(dn_p));

    // Up+down together cancel; mode wins over either of them.
    assign up_ev = up_p & ~dn_p & ~mode_p;
    assign dn_ev = dn_p & ~up_p & ~mode_p;

    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        load_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mode_p) begin
                    state_d = ST_SET_HOUR;
                    hour_d  = (i_hour > HOUR_MAX) ? 7'd0 : i_hour;
                    min_d   = (i_min > MIN_MAX) ? 7'd0 : i_min;
                end
            end
            ST_SET_HOUR: begin
                if (mode_p)     state_d = ST_SET_MIN;
                else if (up_ev) hour_d  = step_wrap(hour_q, HOUR_MAX, 1'b1);
                else if (dn_ev) hour_d  = step_wrap(hour_q, HOUR_MAX, 1'b0);
            end
            ST_SET_MIN: begin
                if (mode_p) begin
                    state_d = ST_RUN;
                    load_d  = 1'b1;
                end
                else if (up_ev) min_d = step_wrap(min_q, MIN_MAX, 1'b1);
                else if (dn_ev) min_d = step_wrap(min_q, MIN_MAX, 1'b0);
            end
            default: state_d = ST_RUN;
        endcase
        setting_d = (state_d != ST_RUN);
        sel_d     = edit_sel_of(state_d);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_RUN;
            hour_q    <= 7'd0;
            min_q     <= 7'd0;
            load_q    <= 1'b0;
            setting_q <= 1'b0;
            sel_q     <= SEL_RUN;
        end else begin
            state_q   <= state_d;
            hour_q    <= hour_d;
            min_q     <= min_d;
            load_q    <= load_d;
            setting_q <= setting_d;
            sel_q     <= sel_d;
        end
    end

    assign o_load     = load_q;
    assign o_set_hour = hour_q;
    assign o_set_min  = min_q;
    assign o_setting  = setting_q;
    assign o_edit_sel = sel_q;

endmodule
